// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
//   Programmable fractional-N baud tick generator for the UART.
//   A phase accumulator overflows at BAUD*OVERSAMPLE on average, giving the
//   oversample tick. A modulo-OVERSAMPLE count of those overflows gives a
//   1x baud tick for TX and a mid-bit tick for RX sampling.
//
// Parameters
//   CLK_FREQ      input clock frequency, Hz
//   DEFAULT_BAUD  baud rate loaded into the increment register at reset
//   ACC_WIDTH     phase accumulator width, bits
//   OVERSAMPLE    oversample ticks per bit (power of 2, >= 2)
//
// Ports
//   i_clock      in   1          system clock, rising edge
//   i_reset      in   1          asynchronous reset, active-high
//   i_enable     in   1          1 = accumulate, 0 = freeze accumulator and count
//   i_resync     in   1          strobe: clear phase and oversample count
//   i_inc_wr     in   1          strobe: load i_inc into the increment register
//   i_inc        in   ACC_WIDTH  new increment (baud*OVERSAMPLE*2**ACC_WIDTH/CLK_FREQ)
//   o_inc        out  ACC_WIDTH  current increment register
//   o_os_tick    out  1          one-cycle pulse per accumulator overflow
//   o_mid_tick   out  1          one-cycle pulse on the mid-bit oversample tick
//   o_baud_tick  out  1          one-cycle pulse per bit period
// ---------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned DEFAULT_BAUD = 19200,
    parameter int unsigned ACC_WIDTH    = 24,
    parameter int unsigned OVERSAMPLE   = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_resync,
    input  logic                 i_inc_wr,
    input  logic [ACC_WIDTH-1:0] i_inc,
    output logic [ACC_WIDTH-1:0] o_inc,
    output logic                 o_os_tick,
    output logic                 o_mid_tick,
    output logic                 o_baud_tick
);

    localparam int unsigned CNT_WIDTH = $clog2(OVERSAMPLE);

    // Computed in 64 bits so the shift cannot overflow for realistic widths.
    localparam logic [63:0] DEFAULT_INC_64 =
        ((64'(DEFAULT_BAUD) * 64'(OVERSAMPLE)) << ACC_WIDTH) / 64'(CLK_FREQ);
    localparam logic [ACC_WIDTH-1:0] DEFAULT_INC = DEFAULT_INC_64[ACC_WIDTH-1:0];

    localparam logic [CNT_WIDTH-1:0] MID_CNT  = CNT_WIDTH'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(OVERSAMPLE - 1);

    // Reject parameter sets that would give a dead or wrapping increment.
    if (DEFAULT_INC_64 == 64'd0 || DEFAULT_INC_64 >= (64'd1 << ACC_WIDTH)) begin : g_bad_inc
        $error("baud_tick_gen: DEFAULT_INC out of range for ACC_WIDTH");
    end
    if (OVERSAMPLE < 2 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
        $error("baud_tick_gen: OVERSAMPLE must be a power of 2 and >= 2");
    end

    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] os_cnt;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;

    // One extra bit catches the overflow that marks an oversample tick.
    assign sum   = {1'b0, acc} + {1'b0, o_inc};
    assign carry = sum[ACC_WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of acc, os_cnt and o_inc; blocking here
    // would let the tick decode see the already-updated count.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            // NOTE: o_inc doubles as the increment register, so its reset
            // value is the derived default rate rather than zero.
            acc         <= '0;
            os_cnt      <= '0;
            o_inc       <= DEFAULT_INC;
            o_os_tick   <= 1'b0;
            o_mid_tick  <= 1'b0;
            o_baud_tick <= 1'b0;
        end else begin
            // Increment load is independent of enable and resync; the add
            // below still uses the old value on the write edge.
            if (i_inc_wr) begin
                o_inc <= i_inc;
            end

            if (i_resync) begin
                acc         <= '0;
                os_cnt      <= '0;
                o_os_tick   <= 1'b0;
                o_mid_tick  <= 1'b0;
                o_baud_tick <= 1'b0;
            end else if (!i_enable) begin
                o_os_tick   <= 1'b0;
                o_mid_tick  <= 1'b0;
                o_baud_tick <= 1'b0;
            end else begin
                acc         <= sum[ACC_WIDTH-1:0];
                o_os_tick   <= carry;
                o_mid_tick  <= carry && (os_cnt == MID_CNT);
                o_baud_tick <= carry && (os_cnt == LAST_CNT);
                if (carry) begin
                    // Power-of-2 OVERSAMPLE makes the natural wrap the modulo.
                    os_cnt <= os_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_baud_tick_gen
//   Self-checking bench for baud_tick_gen with ACC_WIDTH=8, OVERSAMPLE=4 and
//   CLK_FREQ/DEFAULT_BAUD chosen so the default increment is 64. Directed
//   scenarios use hand-derived expectations; a random run is compared to an
//   arithmetic reference model (phase modulo 2**W, unbounded tick count).
// ---------------------------------------------------------------------------
module tb_baud_tick_gen;

    localparam int W       = 8;
    localparam int OS      = 4;
    localparam int MOD     = 256;
    localparam int DEF_INC = 64;

    logic         i_clock = 1'b0;
    logic         i_reset;
    logic         i_enable;
    logic         i_resync;
    logic         i_inc_wr;
    logic [W-1:0] i_inc;
    logic [W-1:0] o_inc;
    logic         o_os_tick;
    logic         o_mid_tick;
    logic         o_baud_tick;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase as plain integer mod 2**W, tick count unbounded.
    int   m_acc;
    int   m_ticks;
    int   m_inc;
    logic e_os, e_mid, e_baud;

    baud_tick_gen #(
        .CLK_FREQ    (16000),
        .DEFAULT_BAUD(1000),
        .ACC_WIDTH   (W),
        .OVERSAMPLE  (OS)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_resync   (i_resync),
        .i_inc_wr   (i_inc_wr),
        .i_inc      (i_inc),
        .o_inc      (o_inc),
        .o_os_tick  (o_os_tick),
        .o_mid_tick (o_mid_tick),
        .o_baud_tick(o_baud_tick)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_acc   = 0;
        m_ticks = 0;
        m_inc   = DEF_INC;
        e_os    = 1'b0;
        e_mid   = 1'b0;
        e_baud  = 1'b0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge and
    // the model is advanced with the inputs that were present at the edge.
    task automatic step();
        logic en, rs, wr;
        int   new_inc;
        int   s;
        en      = i_enable;
        rs      = i_resync;
        wr      = i_inc_wr;
        new_inc = int'(i_inc);
        @(posedge i_clock);
        #1;
        if (rs) begin
            m_acc   = 0;
            m_ticks = 0;
            e_os    = 1'b0;
            e_mid   = 1'b0;
            e_baud  = 1'b0;
        end else if (!en) begin
            e_os   = 1'b0;
            e_mid  = 1'b0;
            e_baud = 1'b0;
        end else begin
            s      = m_acc + m_inc;
            e_os   = (s >= MOD);
            e_mid  = e_os && (m_ticks % OS == OS / 2 - 1);
            e_baud = e_os && (m_ticks % OS == OS - 1);
            if (e_os) m_ticks++;
            m_acc = s % MOD;
        end
        if (wr) m_inc = new_inc;
    endtask

    task automatic apply_reset();
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_resync = 1'b0;
        i_inc_wr = 1'b0;
        i_inc    = '0;
        @(posedge i_clock);
        #3;
        i_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_resync = 1'b0;
        i_inc_wr = 1'b0;
        i_inc    = '0;
        #2;
        checks++;
        if ({o_os_tick, o_mid_tick, o_baud_tick} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ticks: got %b expected 000", {o_os_tick, o_mid_tick, o_baud_tick});
        end
        checks++;
        if (o_inc !== W'(DEF_INC)) begin
            failures++;
            $display("FAIL reset_inc: got %0d expected %0d", o_inc, DEF_INC);
        end
        @(posedge i_clock);
        #3;
        i_reset = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({o_os_tick, o_mid_tick, o_baud_tick, o_inc} !== {3'b000, W'(DEF_INC)}) begin
                failures++;
                $display("FAIL reset_idle: got ticks=%b inc=%0d expected ticks=000 inc=%0d",
                         {o_os_tick, o_mid_tick, o_baud_tick}, o_inc, DEF_INC);
            end
        end
    endtask

    task automatic test_default_rate();
        logic [2:0] exp_t;
        apply_reset();
        i_enable = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            exp_t = {(c % 4 == 0), (c == 8), (c == 16)};
            checks++;
            if ({o_os_tick, o_mid_tick, o_baud_tick} !== exp_t) begin
                failures++;
                $display("FAIL default_rate cycle %0d: got os/mid/baud=%b expected %b",
                         c, {o_os_tick, o_mid_tick, o_baud_tick}, exp_t);
            end
            checks++;
            if (o_inc !== W'(DEF_INC)) begin
                failures++;
                $display("FAIL default_rate_inc cycle %0d: got %0d expected %0d", c, o_inc, DEF_INC);
            end
        end
    endtask

    task automatic test_fractional();
        int n_os, n_baud, last, gap_exp;
        apply_reset();
        i_enable = 1'b1;
        i_inc_wr = 1'b1;
        i_inc    = W'(96);
        step();
        i_inc_wr = 1'b0;
        checks++;
        if (o_inc !== W'(96)) begin
            failures++;
            $display("FAIL frac_inc_load: got %0d expected 96", o_inc);
        end
        i_resync = 1'b1;
        step();
        i_resync = 1'b0;
        checks++;
        if ({o_os_tick, o_mid_tick, o_baud_tick} !== 3'b000) begin
            failures++;
            $display("FAIL frac_resync_ticks: got %b expected 000", {o_os_tick, o_mid_tick, o_baud_tick});
        end
        n_os = 0;
        n_baud = 0;
        last = 0;
        for (int c = 1; c <= 96; c++) begin
            step();
            checks++;
            if ({o_os_tick, o_mid_tick, o_baud_tick} !== {e_os, e_mid, e_baud}) begin
                failures++;
                $display("FAIL frac_model cycle %0d: got %b expected %b",
                         c, {o_os_tick, o_mid_tick, o_baud_tick}, {e_os, e_mid, e_baud});
            end
            if (o_os_tick) begin
                gap_exp = (n_os % 3 == 2) ? 2 : 3;
                checks++;
                if (c - last !== gap_exp) begin
                    failures++;
                    $display("FAIL frac_spacing tick %0d: got gap %0d expected %0d", n_os, c - last, gap_exp);
                end
                last = c;
                n_os++;
            end
            if (o_baud_tick) n_baud++;
        end
        checks++;
        if (n_os !== 36) begin
            failures++;
            $display("FAIL frac_os_count: got %0d expected 36", n_os);
        end
        checks++;
        if (n_baud !== 9) begin
            failures++;
            $display("FAIL frac_baud_count: got %0d expected 9", n_baud);
        end
    endtask

    task automatic test_enable_gap();
        int n;
        logic [2:0] exp_t;
        apply_reset();
        i_enable = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            step();
            if (o_os_tick) n++;
        end
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL gap_wait: got %0d os ticks expected 2 within budget", n);
        end
        i_enable = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            checks++;
            if ({o_os_tick, o_mid_tick, o_baud_tick} !== 3'b000) begin
                failures++;
                $display("FAIL gap_disabled cycle %0d: got %b expected 000", c, {o_os_tick, o_mid_tick, o_baud_tick});
            end
        end
        i_enable = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            exp_t = {(c % 4 == 0), 1'b0, (c == 8)};
            checks++;
            if ({o_os_tick, o_mid_tick, o_baud_tick} !== exp_t) begin
                failures++;
                $display("FAIL gap_resume cycle %0d: got %b expected %b", c, {o_os_tick, o_mid_tick, o_baud_tick}, exp_t);
            end
        end
    endtask

    task automatic test_resync();
        int n;
        logic [2:0] exp_t;
        apply_reset();
        i_enable = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            step();
            if (o_os_tick) n++;
        end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL resync_wait: got %0d os ticks expected 3 within budget", n);
        end
        step();
        i_resync = 1'b1;
        step();
        i_resync = 1'b0;
        checks++;
        if ({o_os_tick, o_mid_tick, o_baud_tick} !== 3'b000) begin
            failures++;
            $display("FAIL resync_edge: got %b expected 000", {o_os_tick, o_mid_tick, o_baud_tick});
        end
        for (int c = 1; c <= 16; c++) begin
            step();
            exp_t = {(c % 4 == 0), (c == 8), (c == 16)};
            checks++;
            if ({o_os_tick, o_mid_tick, o_baud_tick} !== exp_t) begin
                failures++;
                $display("FAIL resync_after cycle %0d: got %b expected %b", c, {o_os_tick, o_mid_tick, o_baud_tick}, exp_t);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        i_enable = 1'b1;
        i_inc_wr = 1'b1;
        i_inc    = W'(96);
        step();
        i_inc_wr = 1'b0;
        n = 0;
        for (int c = 0; c < 10 && n == 0; c++) begin
            step();
            if (o_os_tick) n++;
        end
        checks++;
        if (n !== 1) begin
            failures++;
            $display("FAIL async_wait: got %0d os ticks expected 1 within budget", n);
        end
        // Now 1 unit after an edge with o_os_tick high; reset lands mid-period.
        #1;
        i_reset = 1'b1;
        #1;
        checks++;
        if ({o_os_tick, o_mid_tick, o_baud_tick} !== 3'b000) begin
            failures++;
            $display("FAIL async_ticks: got %b expected 000", {o_os_tick, o_mid_tick, o_baud_tick});
        end
        checks++;
        if (o_inc !== W'(DEF_INC)) begin
            failures++;
            $display("FAIL async_inc: got %0d expected %0d", o_inc, DEF_INC);
        end
        #1;
        i_reset = 1'b0;
        model_reset();
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (o_os_tick !== (c == 4)) begin
                failures++;
                $display("FAIL async_restart cycle %0d: got os=%b expected %b", c, o_os_tick, (c == 4));
            end
        end
    endtask

    task automatic test_extreme_inc();
        int n_os;
        apply_reset();
        i_enable = 1'b1;
        i_inc_wr = 1'b1;
        i_inc    = W'(255);
        step();
        i_inc_wr = 1'b0;
        i_resync = 1'b1;
        step();
        i_resync = 1'b0;
        n_os = 0;
        for (int c = 1; c <= 256; c++) begin
            step();
            if (o_os_tick) n_os++;
            checks++;
            if ({o_os_tick, o_mid_tick, o_baud_tick} !== {e_os, e_mid, e_baud}) begin
                failures++;
                $display("FAIL inc255_model cycle %0d: got %b expected %b",
                         c, {o_os_tick, o_mid_tick, o_baud_tick}, {e_os, e_mid, e_baud});
            end
        end
        checks++;
        if (n_os !== 255) begin
            failures++;
            $display("FAIL inc255_count: got %0d expected 255", n_os);
        end
        for (int c = 0; c < 3; c++) step();
        i_inc_wr = 1'b1;
        i_inc    = '0;
        step();
        i_inc_wr = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            checks++;
            if ({o_os_tick, o_mid_tick, o_baud_tick} !== 3'b000) begin
                failures++;
                $display("FAIL inc0_ticks cycle %0d: got %b expected 000", c, {o_os_tick, o_mid_tick, o_baud_tick});
            end
        end
        // The held phase decides when ticks resume with a new increment.
        i_inc_wr = 1'b1;
        i_inc    = W'(16);
        step();
        i_inc_wr = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step();
            checks++;
            if ({o_os_tick, o_mid_tick, o_baud_tick, o_inc} !== {e_os, e_mid, e_baud, W'(m_inc)}) begin
                failures++;
                $display("FAIL inc0_hold cycle %0d: got %b inc=%0d expected %b inc=%0d",
                         c, {o_os_tick, o_mid_tick, o_baud_tick}, o_inc, {e_os, e_mid, e_baud}, m_inc);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            i_enable = ($urandom_range(0, 9) != 0);
            i_resync = ($urandom_range(0, 39) == 0);
            i_inc_wr = ($urandom_range(0, 24) == 0);
            i_inc    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(1, 100));
            step();
            checks++;
            if ({o_os_tick, o_mid_tick, o_baud_tick, o_inc} !== {e_os, e_mid, e_baud, W'(m_inc)}) begin
                failures++;
                $display("FAIL random cycle %0d: got %b inc=%0d expected %b inc=%0d",
                         c, {o_os_tick, o_mid_tick, o_baud_tick}, o_inc, {e_os, e_mid, e_baud}, m_inc);
            end
        end
        i_enable = 1'b0;
        i_resync = 1'b0;
        i_inc_wr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_rate();
        test_fractional();
        test_enable_gap();
        test_resync();
        test_async_reset();
        test_extreme_inc();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
